// File: rtl/dest_hazard_scoreboard.sv
// WISC destination decode plus in-flight write scoreboard.
// Stalls issue on RAW hazards against pending register-file writes.
module dest_hazard_scoreboard #(
  parameter int         DEPTH     = 3,
  parameter bit         BYPASS_WB = 1'b0,
  parameter logic [2:0] LINK_REG  = 3'd7
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        flush,
  input  logic        in_valid,
  input  logic [15:0] instr,
  output logic        in_ready,
  output logic        dec_valid,
  output logic        dec_we,
  output logic [2:0]  dec_rd,
  output logic        wb_valid,
  output logic [2:0]  wb_rd,
  output logic [7:0]  busy_mask,
  output logic [15:0] stall_cnt
);

  localparam int NCMP = BYPASS_WB ? DEPTH - 1 : DEPTH;

  logic [DEPTH-1:0] r_v;
  logic [DEPTH-1:0] r_we;
  logic [2:0]       r_rd [DEPTH];
  logic             r_dec_valid;
  logic             r_dec_we;
  logic [2:0]       r_dec_rd;
  logic [15:0]      r_stall;

  logic [4:0] w_op;
  logic       w_we;
  logic [2:0] w_rd;
  logic [2:0] w_rs;
  logic [2:0] w_rt;
  logic       w_rs_use;
  logic       w_rt_use;
  logic       w_hit;
  logic       w_hazard;
  logic       w_ready;
  logic [7:0] w_busy;
  logic       w_unused_bits;

  assign w_op          = instr[15:11];
  assign w_rt          = instr[7:5];
  assign w_unused_bits = ^instr[1:0];

  always_comb begin
    w_we = 1'b0;
    w_rd = 3'd0;
    unique casez (w_op)
      5'b11011, 5'b111??, 5'b11001: begin
        w_we = 1'b1;
        w_rd = instr[4:2];
      end
      5'b010??, 5'b101??, 5'b10001: begin
        w_we = 1'b1;
        w_rd = instr[7:5];
      end
      5'b11000, 5'b10010, 5'b10011: begin
        w_we = 1'b1;
        w_rd = instr[10:8];
      end
      5'b00110, 5'b00111: begin
        w_we = 1'b1;
        w_rd = LINK_REG;
      end
      default: ;
    endcase
  end

  // RET has no rs field but implicitly reads the link register
  always_comb begin
    w_rs     = (w_op == 5'b01110) ? 3'd7 : instr[10:8];
    w_rs_use = 1'b1;
    case (w_op)
      5'b00100, 5'b00110, 5'b11000, 5'b00000,
      5'b00001, 5'b00010, 5'b00011: w_rs_use = 1'b0;
      default: ;
    endcase
    w_rt_use = (w_op == 5'b11011) || (w_op[4:2] == 3'b111) ||
               (w_op == 5'b10000) || (w_op == 5'b10011);
  end

  always_comb begin
    w_hit = 1'b0;
    for (int k = 0; k < NCMP; k++) begin
      if (r_v[k] && r_we[k] &&
          ((w_rs_use && (r_rd[k] == w_rs)) ||
           (w_rt_use && (r_rd[k] == w_rt))))
        w_hit = 1'b1;
    end
  end

  always_comb begin
    w_busy = 8'd0;
    for (int k = 0; k < DEPTH; k++) begin
      if (r_v[k] && r_we[k])
        w_busy[r_rd[k]] = 1'b1;
    end
  end

  assign w_hazard = in_valid & w_hit;
  assign w_ready  = in_valid & ~w_hit & ~flush;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_v  <= '0;
      r_we <= '0;
      for (int k = 0; k < DEPTH; k++)
        r_rd[k] <= 3'd0;
    end else begin
      r_v[0]  <= w_ready;
      r_we[0] <= w_we;
      r_rd[0] <= w_rd;
      for (int k = 1; k < DEPTH; k++) begin
        r_v[k]  <= r_v[k-1] & ~flush;
        r_we[k] <= r_we[k-1];
        r_rd[k] <= r_rd[k-1];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_dec_valid <= 1'b0;
      r_dec_we    <= 1'b0;
      r_dec_rd    <= 3'd0;
      r_stall     <= 16'd0;
    end else begin
      r_dec_valid <= w_ready;
      r_dec_we    <= w_ready & w_we;
      r_dec_rd    <= w_ready ? w_rd : 3'd0;
      if (w_hazard && !flush && (r_stall != 16'hFFFF))
        r_stall <= r_stall + 16'd1;
    end
  end

  assign in_ready  = w_ready;
  assign dec_valid = r_dec_valid;
  assign dec_we    = r_dec_we;
  assign dec_rd    = r_dec_rd;
  assign wb_valid  = r_v[DEPTH-1] & r_we[DEPTH-1];
  assign wb_rd     = r_rd[DEPTH-1];
  assign busy_mask = w_busy;
  assign stall_cnt = r_stall;

endmodule

// File: tb/tb_dest_hazard_scoreboard.sv
// Directed bench for dest_hazard_scoreboard.
// Four configurations share one stimulus stream.
module tb_dest_hazard_scoreboard;

  logic        clk = 1'b0;
  logic        rst;
  logic        flush;
  logic        in_valid;
  logic [15:0] instr;

  logic        rdy [4];
  logic        dv  [4];
  logic        dwe [4];
  logic [2:0]  drd [4];
  logic        wv  [4];
  logic [2:0]  wrd [4];
  logic [7:0]  bm  [4];
  logic [15:0] sc  [4];

  int n_err = 0;
  int n_chk = 0;

  always #5 clk = ~clk;

  dest_hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1'b0)) u_a (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .instr(instr), .in_ready(rdy[0]), .dec_valid(dv[0]),
    .dec_we(dwe[0]), .dec_rd(drd[0]), .wb_valid(wv[0]),
    .wb_rd(wrd[0]), .busy_mask(bm[0]), .stall_cnt(sc[0]));

  dest_hazard_scoreboard #(.DEPTH(3), .BYPASS_WB(1'b1)) u_b (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .instr(instr), .in_ready(rdy[1]), .dec_valid(dv[1]),
    .dec_we(dwe[1]), .dec_rd(drd[1]), .wb_valid(wv[1]),
    .wb_rd(wrd[1]), .busy_mask(bm[1]), .stall_cnt(sc[1]));

  dest_hazard_scoreboard #(.DEPTH(1), .BYPASS_WB(1'b1)) u_c (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .instr(instr), .in_ready(rdy[2]), .dec_valid(dv[2]),
    .dec_we(dwe[2]), .dec_rd(drd[2]), .wb_valid(wv[2]),
    .wb_rd(wrd[2]), .busy_mask(bm[2]), .stall_cnt(sc[2]));

  dest_hazard_scoreboard #(.DEPTH(4), .BYPASS_WB(1'b0)) u_d (
    .clk(clk), .rst(rst), .flush(flush), .in_valid(in_valid),
    .instr(instr), .in_ready(rdy[3]), .dec_valid(dv[3]),
    .dec_we(dwe[3]), .dec_rd(drd[3]), .wb_valid(wv[3]),
    .wb_rd(wrd[3]), .busy_mask(bm[3]), .stall_cnt(sc[3]));

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic drain();
    @(negedge clk);
    in_valid = 1'b0;
    flush    = 1'b0;
    repeat (5) @(negedge clk);
  endtask

  logic [15:0] sw_i  [5] = '{16'hD94C, 16'hC512, 16'h3000, 16'h8140, 16'h0800};
  logic        sw_we [5] = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
  logic [2:0]  sw_rd [5] = '{3'd3, 3'd5, 3'd7, 3'd0, 3'd0};

  initial begin
    rst = 1'b1; flush = 1'b0; in_valid = 1'b0; instr = 16'h0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("rst_dv",   32'(dv[0]),  32'd0);
    chk("rst_dwe",  32'(dwe[0]), 32'd0);
    chk("rst_drd",  32'(drd[0]), 32'd0);
    chk("rst_wv",   32'(wv[0]),  32'd0);
    chk("rst_wrd",  32'(wrd[0]), 32'd0);
    chk("rst_bm",   32'(bm[0]),  32'd0);
    chk("rst_sc",   32'(sc[0]),  32'd0);

    // decode sweep, no dependencies between these
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      instr = sw_i[i]; in_valid = 1'b1;
      #1 chk("sw_rdy", 32'(rdy[0]), 32'd1);
      @(posedge clk);
      #1;
      chk("sw_dv",  32'(dv[0]),  32'd1);
      chk("sw_dwe", 32'(dwe[0]), 32'(sw_we[i]));
      chk("sw_drd", 32'(drd[0]), 32'(sw_rd[i]));
    end
    chk("sw_bm_a",  32'(bm[0]),  32'h80);
    chk("sw_wv_a",  32'(wv[0]),  32'd1);
    chk("sw_wrd_a", 32'(wrd[0]), 32'd7);
    chk("sw_bm_d",  32'(bm[3]),  32'hA0);
    chk("sw_wrd_d", 32'(wrd[3]), 32'd5);
    chk("sw_wv_c",  32'(wv[2]),  32'd0);
    drain();
    chk("drain_bm", 32'(bm[0]), 32'd0);

    // RAW: ADD r3 then ADDI r4,r3 held valid
    @(negedge clk);
    instr = 16'hD94C; in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h4381;
    for (int i = 0; i < 5; i++) begin
      #1;
      chk("raw_rdy_a", 32'(rdy[0]), 32'(i >= 3));
      chk("raw_rdy_b", 32'(rdy[1]), 32'(i >= 2));
      chk("raw_rdy_c", 32'(rdy[2]), 32'd1);
      chk("raw_rdy_d", 32'(rdy[3]), 32'(i >= 4));
      chk("raw_bm3_a", 32'(bm[0][3]), 32'(i < 3));
      @(negedge clk);
    end
    in_valid = 1'b0;
    #1;
    chk("raw_sc_a", 32'(sc[0]), 32'd3);
    chk("raw_sc_b", 32'(sc[1]), 32'd2);
    chk("raw_sc_c", 32'(sc[2]), 32'd0);
    chk("raw_sc_d", 32'(sc[3]), 32'd4);
    chk("raw_dv_a", 32'(dv[0]), 32'd1);
    chk("raw_drd_a", 32'(drd[0]), 32'd4);
    drain();

    // no false hazards: LBI r5, ADD r3,r1,r2, ST reads r1/r2
    @(negedge clk);
    instr = 16'hC512; in_valid = 1'b1;
    @(negedge clk);
    instr = 16'hD94C;
    #1 chk("nf_add_rdy", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    instr = 16'h8140;
    #1 chk("nf_st_rdy_a", 32'(rdy[0]), 32'd1);
    chk("nf_st_rdy_d", 32'(rdy[3]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1 chk("nf_sc_a", 32'(sc[0]), 32'd3);
    drain();

    // RET depends on the JAL link write
    @(negedge clk);
    instr = 16'h3000; in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h7000;
    #1;
    chk("ret_rdy_a", 32'(rdy[0]), 32'd0);
    chk("ret_rdy_c", 32'(rdy[2]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    drain();

    // flush during a stall
    @(negedge clk);
    instr = 16'hD94C; in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h4381;
    #1 chk("fl_stall", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    flush = 1'b1;
    #1;
    chk("fl_rdy_a", 32'(rdy[0]), 32'd0);
    chk("fl_rdy_c", 32'(rdy[2]), 32'd0);
    @(negedge clk);
    flush = 1'b0;
    #1;
    chk("fl_bm",    32'(bm[0]), 32'd0);
    chk("fl_dv_a",  32'(dv[0]), 32'd0);
    chk("fl_dv_c",  32'(dv[2]), 32'd0);
    chk("fl_rdy2",  32'(rdy[0]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("fl_acc_dv",  32'(dv[0]),  32'd1);
    chk("fl_acc_drd", 32'(drd[0]), 32'd4);
    chk("fl_sc_a",    32'(sc[0]),  32'd5);
    drain();

    // reset in the middle of a stall
    @(negedge clk);
    instr = 16'hD94C; in_valid = 1'b1;
    @(negedge clk);
    instr = 16'h4381;
    #1 chk("mr_stall", 32'(rdy[0]), 32'd0);
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mr_dv",  32'(dv[0]),  32'd0);
    chk("mr_dwe", 32'(dwe[0]), 32'd0);
    chk("mr_drd", 32'(drd[0]), 32'd0);
    chk("mr_wv",  32'(wv[0]),  32'd0);
    chk("mr_wrd", 32'(wrd[0]), 32'd0);
    chk("mr_bm",  32'(bm[0]),  32'd0);
    chk("mr_sc",  32'(sc[0]),  32'd0);
    chk("mr_rdy", 32'(rdy[0]), 32'd1);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("mr_acc_dv",  32'(dv[0]),  32'd1);
    chk("mr_acc_drd", 32'(drd[0]), 32'd4);
    drain();

    // saturation: ADDI r3,r3,0 stalls on itself every issue
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    instr = 16'h4360; in_valid = 1'b1;
    repeat (81925) @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    #1;
    chk("sat_sc_d", 32'(sc[3]), 32'hFFFF);
    chk("sat_sc_a", 32'(sc[0]), 32'hF003);
    chk("sat_sc_b", 32'(sc[1]), 32'hD558);
    chk("sat_sc_c", 32'(sc[2]), 32'd0);

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
